// File: rtl/dec_pkg.sv
// Shared decoder definitions: scan FSM states and the one-hot decode helper
// used by every decoder block in this slice.
package dec_pkg;

    // Largest supported select width; helpers work on this width and callers
    // slice down to their own 2^N lines.
    localparam int MAX_N = 6;
    localparam int MAX_W = 1 << MAX_N;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    // One-hot decode of code; active_low inverts so the selected line is 0.
    function automatic logic [MAX_W-1:0] onehot_decode(input logic [MAX_N-1:0] code,
                                                       input logic             active_low);
        logic [MAX_W-1:0] lines;
        lines       = '0;
        lines[code] = 1'b1;
        return active_low ? ~lines : lines;
    endfunction

endpackage

// File: rtl/dec_func_scan_if.sv
// Control/result bundle of dec_func_scan. The master drives the decoder
// inputs and scan start; the slave (the decoder) returns lines, F and scan results.
interface dec_func_scan_if #(
    parameter int N = 4
);
    localparam int W = 1 << N;

    logic         en;
    logic         mode;
    logic [N-1:0] sel;
    logic [W-1:0] minterm_mask;
    logic         start;
    logic [W-1:0] dec_out;
    logic         f_out;
    logic [N-1:0] scan_code;
    logic         busy;
    logic         done;
    logic [W-1:0] truth_vec;

    modport master (
        output en, mode, sel, minterm_mask, start,
        input  dec_out, f_out, scan_code, busy, done, truth_vec
    );

    modport slave (
        input  en, mode, sel, minterm_mask, start,
        output dec_out, f_out, scan_code, busy, done, truth_vec
    );

endinterface

// File: rtl/dec_core.sv
// Combinational N-to-2^N decode with enable and output polarity, plus the
// Boolean function F = OR of the asserted lines selected by the minterm mask.
module dec_core
    import dec_pkg::*;
#(
    parameter int N          = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              en,
    input  logic [N-1:0]      code,
    input  logic [(1<<N)-1:0] mask,
    output logic [(1<<N)-1:0] lines,
    output logic              f
);
    localparam int W = 1 << N;

    logic [MAX_W-1:0] hot;

    // Decode active-high once, then apply enable and polarity; F uses the raw one-hot.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        hot   = onehot_decode(MAX_N'(code), 1'b0);
        lines = {W{ACTIVE_LOW}};
        f     = 1'b0;
        if (en) begin
            lines = hot[W-1:0] ^ {W{ACTIVE_LOW}};
            f     = |(hot & MAX_W'(mask));
        end
    end

endmodule

// File: rtl/dec_func_scan.sv
// Registered decoder with masked-OR function output and an on-chip scan
// sequencer that sweeps every code and captures F into a truth vector.
module dec_func_scan
    import dec_pkg::*;
#(
    parameter int N          = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DWELL      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dec_func_scan_if.slave  bus
);
    localparam int             W          = 1 << N;
    localparam int             CW         = $clog2(DWELL + 1);
    localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]   LAST_CODE  = {N{1'b1}};

    scan_state_t   state;
    logic [CW-1:0] dwell_cnt;
    logic [W-1:0]  shadow_mask;
    logic [N-1:0]  scan_code;
    logic [W-1:0]  dec_out;
    logic          f_out;
    logic          busy;
    logic          done;
    logic [W-1:0]  truth_vec;

    logic [N-1:0]  core_code;
    logic [W-1:0]  core_mask;
    logic [W-1:0]  core_lines;
    logic          core_f;

    // While scanning the sequencer owns the decoder; otherwise the live inputs do.
    always_comb begin
        core_code = bus.sel;
        core_mask = bus.minterm_mask;
        if (state == SCAN) begin
            core_code = scan_code;
            core_mask = shadow_mask;
        end
    end

    dec_core #(
        .N          (N),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .en    (bus.en),
        .code  (core_code),
        .mask  (core_mask),
        .lines (core_lines),
        .f     (core_f)
    );

    // Output registers, scan FSM, dwell counter and per-code capture of F.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: truth_vec and shadow_mask are plain registers, not RAM, so
            // they take the async reset; a reset mid-scan must clear the result.
            state       <= IDLE;
            dec_out     <= {W{ACTIVE_LOW}};
            f_out       <= 1'b0;
            scan_code   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_vec   <= '0;
            shadow_mask <= '0;
            dwell_cnt   <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge values.
            dec_out <= core_lines;
            f_out   <= core_f;
            case (state)
                IDLE: begin
                    if (bus.start && bus.mode && bus.en) begin
                        state       <= SCAN;
                        busy        <= 1'b1;
                        truth_vec   <= '0;
                        shadow_mask <= bus.minterm_mask;
                        scan_code   <= '0;
                        dwell_cnt   <= '0;
                    end
                end
                SCAN: begin
                    // en low pauses the scan: counter, code and truth_vec all hold.
                    if (bus.en) begin
                        if (dwell_cnt == DWELL_LAST) begin
                            dwell_cnt            <= '0;
                            truth_vec[scan_code] <= core_f;
                            scan_code            <= scan_code + N'(1);
                            if (scan_code == LAST_CODE) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dec_out   = dec_out;
    assign bus.f_out     = f_out;
    assign bus.scan_code = scan_code;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.truth_vec = truth_vec;

endmodule

// File: tb/tb_dec_func_scan.sv
// Directed bench for dec_func_scan: table-driven direct-mode vectors plus
// hand-written scan sequences (mask change, pause, restart, reset mid-scan).
module tb_dec_func_scan;

    logic clk = 1'b0;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dec_func_scan_if #(.N(4)) bus ();
    dec_func_scan_if #(.N(4)) bus2 ();

    dec_func_scan #(
        .N          (4),
        .ACTIVE_LOW (1'b1),
        .DWELL      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dec_func_scan #(
        .N          (4),
        .ACTIVE_LOW (1'b0),
        .DWELL      (1)
    ) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic        en;
        logic [3:0]  sel;
        logic [15:0] mask;
        logic [15:0] exp_dec;
        logic        exp_f;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One scan with optional pause at code 7, restart attempt and mid-scan mask change.
    task automatic run_scan(input int pause_len, input bit restart, input bit change_mask,
                            output int busy_cycles, output int done_cnt);
        int paused;
        bit pause_done;
        int post;
        busy_cycles = 0;
        done_cnt    = 0;
        paused      = 0;
        pause_done  = 1'b0;
        post        = 0;
        @(negedge clk);
        bus.mode         = 1'b1;
        bus.en           = 1'b1;
        bus.sel          = 4'd5;
        bus.minterm_mask = 16'h0DD0;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("scan_first_busy", bus.busy, 1);
        check("scan_first_code", bus.scan_code, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) done_cnt++;
            if (done_cnt > 0) post++;
            if (post >= 5) break;
            if (cyc == 1) check("scan_code0_dec", bus.dec_out, 16'hFFFE);
            if (change_mask && cyc == 20) bus.minterm_mask = 16'hFFFF;
            bus.start = (restart && cyc == 30);
            if (pause_len > 0 && !pause_done && paused == 0 && bus.scan_code == 4'd7) begin
                bus.en = 1'b0;
                paused = 1;
            end else if (paused > 0) begin
                check("pause_code_hold", bus.scan_code, 7);
                check("pause_dec_inactive", bus.dec_out, 16'hFFFF);
                check("pause_f_zero", bus.f_out, 0);
                if (paused == pause_len) begin
                    bus.en     = 1'b1;
                    paused     = 0;
                    pause_done = 1'b1;
                end else begin
                    paused++;
                end
            end
            @(negedge clk);
        end
        check("scan_ends_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int dc;
        bit found;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 4'(i), 16'h0DD0, ~(16'h0001 << i),
                        (i inside {4, 6, 7, 8, 10, 11})};
        end
        vecs[16] = '{1'b0, 4'd5,  16'h0DD0, 16'hFFFF, 1'b0};
        vecs[17] = '{1'b1, 4'd5,  16'hFFFF, 16'hFFDF, 1'b1};
        vecs[18] = '{1'b1, 4'd4,  16'h0000, 16'hFFEF, 1'b0};
        vecs[19] = '{1'b1, 4'd15, 16'h8000, 16'h7FFF, 1'b1};

        // Reset with random inputs
        rst_n             = 1'b0;
        bus.en            = 1'($urandom);
        bus.mode          = 1'($urandom);
        bus.sel           = 4'($urandom);
        bus.minterm_mask  = 16'($urandom);
        bus.start         = 1'($urandom);
        bus2.en           = 1'b1;
        bus2.mode         = 1'b0;
        bus2.sel          = 4'd3;
        bus2.minterm_mask = 16'h0008;
        bus2.start        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dec", bus.dec_out, 16'hFFFF);
        check("rst_f", bus.f_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_code", bus.scan_code, 0);
        check("rst_truth", bus.truth_vec, 0);
        check("rst_dec_hi", bus2.dec_out, 16'h0000);
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.en    = 1'b1;
        rst_n     = 1'b1;

        // Direct-mode vector table
        for (int i = 0; i < 20; i++) begin
            bus.en           = vecs[i].en;
            bus.sel          = vecs[i].sel;
            bus.minterm_mask = vecs[i].mask;
            @(negedge clk);
            check($sformatf("vec%0d_dec", i), bus.dec_out, vecs[i].exp_dec);
            check($sformatf("vec%0d_f", i), bus.f_out, vecs[i].exp_f);
        end

        // Active-high build
        bus2.sel = 4'd3;
        @(negedge clk);
        check("hi_sel3_dec", bus2.dec_out, 16'h0008);
        check("hi_sel3_f", bus2.f_out, 1);
        bus2.sel = 4'd2;
        @(negedge clk);
        check("hi_sel2_dec", bus2.dec_out, 16'h0004);
        check("hi_sel2_f", bus2.f_out, 0);

        // start with mode = 0, then start with en = 0: both ignored
        bus.en    = 1'b1;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        check("start_mode0_ignored", bus.busy, 0);
        bus.mode = 1'b1;
        bus.en   = 1'b0;
        @(negedge clk);
        check("start_en0_ignored", bus.busy, 0);
        bus.start = 1'b0;
        bus.en    = 1'b1;

        // Scan 1: plain scan with mask change mid-scan
        run_scan(0, 1'b0, 1'b1, bc, dc);
        check("scan1_busy_cycles", bc, 48);
        check("scan1_done_pulses", dc, 1);
        check("scan1_truth", bus.truth_vec, 16'h0DD0);
        repeat (3) @(negedge clk);
        check("scan1_truth_stable", bus.truth_vec, 16'h0DD0);

        // Scan 2: 5-cycle pause at code 7 plus start while busy
        run_scan(5, 1'b1, 1'b0, bc, dc);
        check("scan2_busy_cycles", bc, 53);
        check("scan2_done_pulses", dc, 1);
        check("scan2_truth", bus.truth_vec, 16'h0DD0);

        // Scan 3: asynchronous reset at code 9
        @(negedge clk);
        bus.minterm_mask = 16'h0DD0;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.scan_code == 4'd9) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_code9", found, 1);
        check("partial_truth", bus.truth_vec, 16'h01D0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_truth", bus.truth_vec, 0);
        check("midrst_code", bus.scan_code, 0);
        check("midrst_dec", bus.dec_out, 16'hFFFF);
        check("midrst_f", bus.f_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan 4: normal scan after reset
        run_scan(0, 1'b0, 1'b0, bc, dc);
        check("scan4_busy_cycles", bc, 48);
        check("scan4_done_pulses", dc, 1);
        check("scan4_truth", bus.truth_vec, 16'h0DD0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
